sbox_arbiter: RTL

Arbiter that shares one registered 128-bit SubBytes unit (16 S-boxes, one-cycle registered latency, no reset, no enable) between two requesters: port 0, the cipher round datapath, and port 1, the key-expansion engine. The arbiter accepts at most one 128-bit state per cycle via valid/ready and drives it into the SubBytes input. It tags each issue so the registered result returns to the requester that issued it. Each requester has a 2-entry response FIFO with independent backpressure.

---
 rtl/sbox_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/sbox_arbiter.sv
// Shares one registered 128-bit SubBytes unit between the cipher round datapath (port 0)
// and the key-expansion engine (port 1); tagged results return into per-port 2-entry FIFOs.
module sbox_arbiter #(
    parameter int RSP_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic [127:0] sub_data_in,
    input  logic [127:0] sub_data_out,
    output logic         rsp0_valid,
    output logic [127:0] rsp0_data,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    output logic [127:0] rsp1_data,
    input  logic         rsp1_ready
);
    logic [1:0] req_valid, rsp_ready, has_rsp, pop, elig, gnt;
    logic       tag_v, tag_id, last;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [127:0] slot0, slot1;
        logic [1:0]   count;
        logic         push;
        logic [2:0]   used, limit;

        // The result returning this cycle is exactly the one issued to this port last cycle.
        always_comb begin
            push  = tag_v && (tag_id == 1'(p));
            used  = {1'b0, count} + {2'b0, push};
            limit = 3'(RSP_DEPTH) + {2'b0, pop[p]};
        end

        assign has_rsp[p] = (count != 2'd0);
        assign pop[p]     = has_rsp[p] && rsp_ready[p];
        assign elig[p]    = rst_n && req_valid[p] && (used < limit);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
                slot0 <= '0;
                slot1 <= '0;
            end else begin
                case ({push, pop[p]})
                    2'b01: begin
                        slot0 <= slot1;
                        count <= count - 2'd1;
                    end
                    2'b10: begin
                        if (count == 2'd0) slot0 <= sub_data_out;
                        else               slot1 <= sub_data_out;
                        count <= count + 2'd1;
                    end
                    2'b11: begin
                        // Head leaves while the new result joins the tail; occupancy is unchanged.
                        if (count == 2'd1) begin
                            slot0 <= sub_data_out;
                        end else begin
                            slot0 <= slot1;
                            slot1 <= sub_data_out;
                        end
                    end
                    default: ;
                endcase
            end
        end

        a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(push && !pop[p] && count == 2'(RSP_DEPTH)));
    end

    always_comb begin
        if (elig == 2'b11) gnt = last ? 2'b01 : 2'b10;
        else               gnt = elig;
        sub_data_in = '0;
        if (gnt[0])      sub_data_in = req0_data;
        else if (gnt[1]) sub_data_in = req1_data;
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp0_valid = has_rsp[0];
    assign rsp1_valid = has_rsp[1];
    assign rsp0_data  = g_port[0].slot0;
    assign rsp1_data  = g_port[1].slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= 1'b0;
            tag_id <= 1'b0;
            last   <= 1'b1;
        end else begin
            tag_v  <= |gnt;
            tag_id <= gnt[1];
            if (|gnt) last <= gnt[1];
        end
    end
endmodule
